// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder built from two half adders and an OR.
module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    logic s1;
    logic c1;
    logic c2;

    // first half adder: a + b
    assign s1 = a ^ b;
    assign c1 = a & b;

    // second half adder: partial sum + carry-in
    assign s  = s1 ^ cin;
    assign c2 = s1 & cin;

    assign c  = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands accepted on a valid/ready handshake,
// resolved LSB first one bit per clock through a single full-adder cell,
// result presented on a second handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one bit resolved per edge, WIDTH edges total
// DONE  | result held with out_valid=1 until out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;

    serial_add_cell u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (bit_s),
        .c   (bit_c)
    );

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (cnt == CNT_LAST);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state and handshake outputs, decoded from registered state only
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // operand/sum shift registers, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
            carry  <= bit_c;
            cnt    <= cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // on the final bit, carry holds the carry into the MSB and bit_c the carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_bit) begin
            ovf <= carry ^ bit_c;
        end
    end
`endif

    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected
// results computed with plain arithmetic; a monitor pops on each new result.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic pv       = 1'b0;
    logic rnd_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        int   total;
        int   st;
        total  = int'(x) + int'(y) + int'(ci);
        st     = int'($signed(x)) + int'($signed(y)) + int'(ci);
        e.sum  = total[W-1:0];
        e.cout = total[W];
        e.ovf  = (st > 127) || (st < -128);
        return e;
    endfunction

    // cycle counter and accept-edge recorder
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    end

    // random downstream backpressure during the random phase
    always @(negedge clk) begin
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // monitor: compare each newly presented result against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid && !pv) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", sum);
                end else begin
                    exp_t e;
                    int   t;
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.ovf));
`endif
                    check("latency", 64'(cyc - t), 64'(W));
                end
            end
            pv = out_valid;
        end
    end

    // present operands and hold in_valid until accepted; returns accept cycle
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input bit keep_valid, output int acc);
        logic got;
        acc      = -1;
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        exp_q.push_back(model(x, y, ci));
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            got = in_ready;
            #1;
            if (got) begin
                acc = cyc;
                break;
            end
        end
        if (!keep_valid) in_valid = 1'b0;
        if (acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !in_ready) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int   t0;
        int   t1;
        int   t2;
        int   k;
        logic [W-1:0] hs;
        logic         hc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        send(8'h0F, 8'h01, 1'b0, 1'b0, t0);
        wait_idle();
        send(8'hFF, 8'h01, 1'b0, 1'b0, t0);
        wait_idle();
        send(8'h7F, 8'h01, 1'b0, 1'b0, t0);
        wait_idle();
        send(8'h00, 8'h00, 1'b1, 1'b0, t0);
        wait_idle();

        // backpressure: hold DONE while pulsing unaccepted operands
        out_ready = 1'b0;
        send(8'hA5, 8'h3C, 1'b1, 1'b0, t0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_reached_done", 64'(out_valid), 64'd1);
        hs = sum;
        hc = cout;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a        = 8'(i * 17 + 3);
            b        = 8'(i * 29 + 1);
            @(negedge clk);
            check("bp_sum_stable", 64'(sum), 64'(hs));
            check("bp_cout_stable", 64'(cout), 64'(hc));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_no_stray_accept", 64'(acc_q.size()), 64'd0);

        // reset in the middle of RUN
        send(8'hC3, 8'h5A, 1'b0, 1'b0, t0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h12, 8'h34, 1'b0, 1'b0, t0);
        wait_idle();

        // back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        send(8'h11, 8'h22, 1'b0, 1'b1, t0);
        send(8'h80, 8'h80, 1'b1, 1'b1, t1);
        send(8'hFE, 8'h01, 1'b1, 1'b0, t2);
        check("b2b_spacing_1", 64'(t1 - t0), 64'd10);
        check("b2b_spacing_2", 64'(t2 - t1), 64'd10);
        wait_idle();

        // random operands with random downstream backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, t0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
